// File: rtl/lcd_refresh.sv
// lcd_refresh: reader-side refresh controller for a 2x16 HD44780-style LCD on a 4-bit bus.
// After reset it waits T_PWRUP and sends the 4-nibble init sequence, then the
// configuration bytes 0x28/0x06/0x0C/0x01. After that it loops forever. Each loop
// sets line 1 (0x80) and writes chars 0..15, then sets line 2 (0xC0) and writes
// chars 16..31.
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   addr[4:0]       character index presented to the character store
//   bus[7:0]        ASCII code returned by the store for addr
//   lcd_d[3:0]      LCD D7..D4
//   lcd_rs          0 = command, 1 = data
//   lcd_rw          always 0 (write-only)
//   lcd_e           enable strobe
//   ready           high from end of init until reset
//   frame_done      one-cycle pulse as each frame completes
module lcd_refresh #(
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_CLEAR = 82000,
  parameter int T_SU    = 2,
  parameter int T_E     = 12,
  parameter int T_NIB   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [4:0] addr,
  input  logic [7:0] bus,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       ready,
  output logic       frame_done
);
  localparam int T_NIBBLE = T_SU + T_E + T_NIB;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT_NIB, S_INIT_WAIT, S_HI, S_LO, S_WAIT, S_FETCH, S_LATCH
  } state_t;
  // What the byte in flight is. This decides where to go after its post-byte wait.
  typedef enum logic [1:0] {K_CFG, K_LINE, K_CHAR} kind_t;

  state_t      state, state_n;
  kind_t       kind, kind_n;
  logic [31:0] cnt, cnt_n;
  logic [1:0]  step, step_n;
  logic [7:0]  byte_q, byte_n;
  logic [4:0]  addr_n;
  logic [3:0]  d_n;
  logic        rs_n, e_n, ready_n, fd_n;
  logic [31:0] init_wait, byte_wait;
  logic [7:0]  nxt_cfg;
  logic        nib_last;

  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  always_comb begin
    case (step)
      2'd0:    init_wait = 32'(T_INIT1);
      2'd1:    init_wait = 32'(T_INIT2);
      default: init_wait = 32'(T_CMD);
    endcase
  end

  // Only the clear command gets the long wait. A data byte of 0x01 does not.
  assign byte_wait = (!lcd_rs && byte_q == 8'h01) ? 32'(T_CLEAR) : 32'(T_CMD);
  assign nxt_cfg   = cfg_byte(step + 2'd1);
  assign nib_last  = (cnt == 32'(T_NIBBLE - 1));
  assign lcd_rw    = 1'b0;

  always_comb begin
    state_n = state;
    kind_n  = kind;
    cnt_n   = cnt + 32'd1;
    step_n  = step;
    byte_n  = byte_q;
    addr_n  = addr;
    d_n     = lcd_d;
    rs_n    = lcd_rs;
    ready_n = ready;
    fd_n    = 1'b0;
    case (state)
      S_PWRUP: if (cnt == 32'(T_PWRUP - 1)) begin
        state_n = S_INIT_NIB; cnt_n = '0; d_n = 4'h3; rs_n = 1'b0; step_n = '0;
      end
      S_INIT_NIB: if (nib_last) begin
        state_n = S_INIT_WAIT; cnt_n = '0;
      end
      S_INIT_WAIT: if (cnt == init_wait - 32'd1) begin
        cnt_n = '0;
        if (step != 2'd3) begin
          state_n = S_INIT_NIB; step_n = step + 2'd1;
          d_n     = (step == 2'd2) ? 4'h2 : 4'h3;
        end else begin
          state_n = S_HI; kind_n = K_CFG; step_n = '0;
          byte_n  = 8'h28; d_n = 4'h2; rs_n = 1'b0;
        end
      end
      S_HI: if (nib_last) begin
        state_n = S_LO; cnt_n = '0; d_n = byte_q[3:0];
      end
      S_LO: if (nib_last) begin
        state_n = S_WAIT; cnt_n = '0;
      end
      S_WAIT: if (cnt == byte_wait - 32'd1) begin
        cnt_n = '0;
        case (kind)
          K_CFG: if (step != 2'd3) begin
            state_n = S_HI; step_n = step + 2'd1;
            byte_n  = nxt_cfg; d_n = nxt_cfg[7:4];
          end else begin
            ready_n = 1'b1;
            state_n = S_HI; kind_n = K_LINE; byte_n = 8'h80; d_n = 4'h8;
          end
          // Line-address command done. bit 6 tells line 2 (0xC0) from line 1 (0x80).
          K_LINE: begin
            state_n = S_FETCH;
            addr_n  = byte_q[6] ? 5'd16 : 5'd0;
          end
          default: if (addr == 5'd15) begin
            state_n = S_HI; kind_n = K_LINE; byte_n = 8'hC0; d_n = 4'hC; rs_n = 1'b0;
          end else if (addr == 5'd31) begin
            fd_n    = 1'b1;
            state_n = S_HI; kind_n = K_LINE; byte_n = 8'h80; d_n = 4'h8; rs_n = 1'b0;
          end else begin
            state_n = S_FETCH; addr_n = addr + 5'd1;
          end
        endcase
      end
      // addr became valid on entry. Allow the store one full cycle before latching.
      S_FETCH: state_n = S_LATCH;
      S_LATCH: begin
        state_n = S_HI; kind_n = K_CHAR; cnt_n = '0;
        byte_n  = bus; d_n = bus[7:4]; rs_n = 1'b1;
      end
      default: state_n = S_PWRUP;
    endcase
    // E is registered from the next-state count. It goes high T_SU cycles into a nibble.
    e_n = (state_n == S_INIT_NIB || state_n == S_HI || state_n == S_LO) &&
          (cnt_n >= 32'(T_SU)) && (cnt_n < 32'(T_SU + T_E));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PWRUP;
      kind       <= K_CFG;
      cnt        <= '0;
      step       <= '0;
      byte_q     <= '0;
      addr       <= '0;
      lcd_d      <= '0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      kind       <= kind_n;
      cnt        <= cnt_n;
      step       <= step_n;
      byte_q     <= byte_n;
      addr       <= addr_n;
      lcd_d      <= d_n;
      lcd_rs     <= rs_n;
      lcd_e      <= e_n;
      ready      <= ready_n;
      frame_done <= fd_n;
    end
  end
endmodule

// File: tb/tb_lcd_refresh.sv
// tb_lcd_refresh: scoreboard bench for lcd_refresh with short timing parameters.
// A monitor captures every nibble at the falling edge of E.
// It compares each one with the expected queue that the scenario tasks fill.
module tb_lcd_refresh;
  localparam int TP = 20, TI1 = 10, TI2 = 6, TCMD = 4, TCLR = 8, TSU = 2, TE = 3, TNIB = 2;
  localparam int NIBC  = TSU + TE + TNIB;
  localparam int BYTEC = 2 * NIBC + TCMD;
  localparam int FRAME = 2 * BYTEC + 32 * (2 + BYTEC);
  localparam int READY = TP + 4 * NIBC + TI1 + TI2 + 2 * TCMD + 3 * BYTEC + 2 * NIBC + TCLR;
  localparam int FIRST_E = TP + TSU;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [4:0] addr;
  logic [7:0] bus;
  logic [3:0] lcd_d;
  logic       lcd_rs, lcd_rw, lcd_e, ready, frame_done;
  logic [7:0] mem [32];

  lcd_refresh #(.T_PWRUP(TP), .T_INIT1(TI1), .T_INIT2(TI2), .T_CMD(TCMD), .T_CLEAR(TCLR),
                .T_SU(TSU), .T_E(TE), .T_NIB(TNIB)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .bus(bus), .lcd_d(lcd_d), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_e(lcd_e), .ready(ready), .frame_done(frame_done));

  always #5 clk = ~clk;
  assign bus = mem[addr];

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  typedef struct packed { logic rs; logic [3:0] d; logic cka; logic [4:0] a; } exp_t;
  exp_t expq[$];
  exp_t x;
  int   ntot = 0, npass = 0;
  int   stab, e_len, first_e, fd_cyc;
  logic prev_e, prev_rs, chg, moved;
  logic [3:0] prev_d;

  function automatic void push_byte(input logic rs, input logic [7:0] b,
                                    input logic cka, input logic [4:0] a);
    expq.push_back(exp_t'({rs, b[7:4], cka, a}));
    expq.push_back(exp_t'({rs, b[3:0], cka, a}));
  endfunction

  function automatic void push_frame(input bit ff5);
    push_byte(1'b0, 8'h80, 1'b0, 5'd0);
    for (int i = 0; i < 16; i++)
      push_byte(1'b1, (ff5 && i == 5) ? 8'hFF : 8'(8'h41 + i), 1'b1, 5'(i));
    push_byte(1'b0, 8'hC0, 1'b0, 5'd0);
    for (int i = 16; i < 32; i++)
      push_byte(1'b1, 8'(8'h41 + i), 1'b1, 5'(i));
  endfunction

  // Monitor: checks E shape and setup/hold, and scores each nibble as E falls.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e = 1'b0; e_len = 0; stab = 0; first_e = -1; moved = 1'b0;
      prev_d = lcd_d; prev_rs = lcd_rs;
    end else begin
      chg  = ({lcd_rs, lcd_d} != {prev_rs, prev_d});
      stab = chg ? 0 : stab + 1;
      if (lcd_e && chg) moved = 1'b1;
      if (lcd_e) e_len++;
      if (lcd_e && !prev_e) begin
        if (first_e < 0) first_e = cyc;
        ntot++;
        if (stab < TSU) $display("FAIL e_setup: got %0d stable cycles want >= %0d", stab, TSU);
        else npass++;
        ntot++;
        if (lcd_rw !== 1'b0) $display("FAIL lcd_rw: got %b want 0", lcd_rw); else npass++;
      end
      if (!lcd_e && prev_e) begin
        ntot++;
        if (e_len != TE) $display("FAIL e_width: got %0d want %0d", e_len, TE); else npass++;
        ntot++;
        if (moved) $display("FAIL e_hold: got d/rs change while E high want none"); else npass++;
        e_len = 0; moved = 1'b0;
        ntot++;
        if (expq.size() == 0) $display("FAIL nibble_extra: got rs=%b d=%h want none", lcd_rs, lcd_d);
        else begin
          x = expq.pop_front();
          if ({lcd_rs, lcd_d} !== {x.rs, x.d})
            $display("FAIL nibble @%0d: got rs=%b d=%h want rs=%b d=%h", cyc, lcd_rs, lcd_d, x.rs, x.d);
          else npass++;
          if (x.cka) begin
            ntot++;
            if (addr !== x.a) $display("FAIL fetch_addr: got %0d want %0d", addr, x.a); else npass++;
          end
        end
      end
      prev_e = lcd_e; prev_d = lcd_d; prev_rs = lcd_rs;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ntot++; if (addr !== 5'd0)       $display("FAIL rst_addr: got %h want 0", addr); else npass++;
    ntot++; if (lcd_d !== 4'd0)      $display("FAIL rst_lcd_d: got %h want 0", lcd_d); else npass++;
    ntot++; if (lcd_rs !== 1'b0)     $display("FAIL rst_rs: got %b want 0", lcd_rs); else npass++;
    ntot++; if (lcd_rw !== 1'b0)     $display("FAIL rst_rw: got %b want 0", lcd_rw); else npass++;
    ntot++; if (lcd_e !== 1'b0)      $display("FAIL rst_e: got %b want 0", lcd_e); else npass++;
    ntot++; if (ready !== 1'b0)      $display("FAIL rst_ready: got %b want 0", ready); else npass++;
    ntot++; if (frame_done !== 1'b0) $display("FAIL rst_fd: got %b want 0", frame_done); else npass++;
  endtask

  // Releases reset and follows power-up, init nibbles and config bytes until ready.
  task automatic test_init;
    int t;
    expq.push_back(exp_t'({1'b0, 4'h3, 1'b0, 5'd0}));
    expq.push_back(exp_t'({1'b0, 4'h3, 1'b0, 5'd0}));
    expq.push_back(exp_t'({1'b0, 4'h3, 1'b0, 5'd0}));
    expq.push_back(exp_t'({1'b0, 4'h2, 1'b0, 5'd0}));
    push_byte(1'b0, 8'h28, 1'b0, 5'd0);
    push_byte(1'b0, 8'h06, 1'b0, 5'd0);
    push_byte(1'b0, 8'h0C, 1'b0, 5'd0);
    push_byte(1'b0, 8'h01, 1'b0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    ntot++; if (cyc != READY) $display("FAIL ready_cycle: got %0d want %0d", cyc, READY); else npass++;
    ntot++; if (first_e != FIRST_E) $display("FAIL first_e_cycle: got %0d want %0d", first_e, FIRST_E); else npass++;
    ntot++; if (expq.size() != 0) $display("FAIL init_left: got %0d pending want 0", expq.size()); else npass++;
  endtask

  task automatic test_first_frame;
    int t;
    push_frame(1'b0);
    t = 0;
    while (addr !== 5'd5 && t < 2000) begin @(negedge clk); t++; end
    ntot++;
    if (addr !== 5'd5) $display("FAIL addr5_wait: got %0d want 5", addr);
    else begin
      npass++;
      @(posedge clk); @(posedge clk);   // second edge latches the byte
      #1 mem[5] = 8'hFF;
    end
    t = 0;
    while (frame_done !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    ntot++; if (cyc != READY + FRAME) $display("FAIL fd1_cycle: got %0d want %0d", cyc, READY + FRAME); else npass++;
    ntot++; if (expq.size() != 0) $display("FAIL frame1_left: got %0d pending want 0", expq.size()); else npass++;
    ntot++; if (ready !== 1'b1) $display("FAIL ready_held: got %b want 1", ready); else npass++;
    fd_cyc = cyc;
    push_frame(1'b1);
    @(negedge clk);
    ntot++; if (frame_done !== 1'b0) $display("FAIL fd_width: got %b want 0", frame_done); else npass++;
  endtask

  task automatic test_frame_wrap;
    int t;
    t = 0;
    while (frame_done !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    ntot++; if (cyc - fd_cyc != FRAME) $display("FAIL frame_period: got %0d want %0d", cyc - fd_cyc, FRAME); else npass++;
    ntot++; if (expq.size() != 0) $display("FAIL frame2_left: got %0d pending want 0", expq.size()); else npass++;
    ntot++; if (addr !== 5'd31) $display("FAIL addr_at_fd: got %0d want 31", addr); else npass++;
    push_frame(1'b1);
  endtask

  task automatic test_reset_mid;
    int t;
    t = 0;
    while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && t < 2000) begin @(negedge clk); t++; end
    ntot++; if (lcd_e !== 1'b1) $display("FAIL mid_e_wait: got %b want 1", lcd_e); else npass++;
    #1 rst_n = 1'b0;
    #1;
    ntot++; if (lcd_e !== 1'b0)      $display("FAIL mid_e: got %b want 0", lcd_e); else npass++;
    ntot++; if (lcd_rs !== 1'b0)     $display("FAIL mid_rs: got %b want 0", lcd_rs); else npass++;
    ntot++; if (lcd_d !== 4'd0)      $display("FAIL mid_d: got %h want 0", lcd_d); else npass++;
    ntot++; if (addr !== 5'd0)       $display("FAIL mid_addr: got %0d want 0", addr); else npass++;
    ntot++; if (ready !== 1'b0)      $display("FAIL mid_ready: got %b want 0", ready); else npass++;
    ntot++; if (frame_done !== 1'b0) $display("FAIL mid_fd: got %b want 0", frame_done); else npass++;
    expq.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h41 + i);
    test_reset;
    test_init;
    test_first_frame;
    test_frame_wrap;
    test_reset_mid;
    test_init;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
